// File: rtl/apb_timer_master.sv
// APB requester for the timer slave: turns a req/gnt/rvalid core interface into
// APB SETUP/ACCESS transfers, with a bounded PREADY wait that aborts hung transfers.
module apb_timer_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [63:0]               wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [63:0]               rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [63:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [63:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  // A zero TIMEOUT_CYCLES still needs a one-bit counter to keep the vector legal.
  localparam int CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_idle;
  logic             w_timeout;

  assign w_idle    = (r_state == IDLE);
  assign gnt_o     = req_i & w_idle & ~HRESET;
  // Fires on the Nth consecutive PREADY-low ACCESS cycle; PREADY high takes priority.
  assign w_timeout = (TIMEOUT_CYCLES > 0) && (r_cnt == TO_LAST);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (gnt_o) begin
            PADDR   <= addr_i;
            PWDATA  <= wdata_i;
            PWRITE  <= we_i;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            r_cnt   <= '0;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          r_state <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            rvalid_o <= 1'b1;
            err_o    <= PSLVERR;
            rdata_o  <= PWRITE ? 64'd0 : PRDATA;
            r_state  <= IDLE;
          end else if (w_timeout) begin
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            rvalid_o <= 1'b1;
            err_o    <= 1'b1;
            rdata_o  <= 64'd0;
            r_state  <= IDLE;
          end else if (TIMEOUT_CYCLES > 0) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_timer_master.sv
// Self-checking bench for apb_timer_master: directed scenarios plus randomized
// transfers checked against a latency/response model derived from the APB rules.
module tb_apb_timer_master;

  localparam int AW = 12;
  localparam int TO = 4;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          req_i;
  logic          we_i;
  logic [AW-1:0] addr_i;
  logic [63:0]   wdata_i;
  logic          gnt_o;
  logic          rvalid_o;
  logic [63:0]   rdata_o;
  logic          err_o;
  logic [AW-1:0] PADDR;
  logic [63:0]   PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [63:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] expRdata = 64'd0;
  logic        expErr = 1'b0;

  apb_timer_master #(
    .APB_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge HCLK);
    #1;
  endtask

  // Bus noise the DUT must ignore outside the completing ACCESS cycle.
  task automatic randomBus();
    PRDATA  = {$urandom, $urandom};
    PSLVERR = 1'($urandom);
    PREADY  = 1'($urandom);
  endtask

  task automatic randomCore();
    we_i    = 1'($urandom);
    addr_i  = AW'($urandom);
    wdata_i = {$urandom, $urandom};
  endtask

  task automatic idleCycles(input int n);
    req_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      nextCycle();
      randomBus();
      checkOutput("idle_psel", 64'(PSEL), 64'd0);
      checkOutput("idle_rvalid", 64'(rvalid_o), 64'd0);
      checkOutput("idle_rdata_hold", rdata_o, expRdata);
      checkOutput("idle_err_hold", 64'(err_o), 64'(expErr));
    end
  endtask

  // One transfer. The model: latency gnt->rvalid is 3+waits when the slave answers
  // before TO low cycles, otherwise 2+TO with a timeout error and zero data.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [63:0] wdata,
                               input int waits, input logic slverr, input logic [63:0] prdata,
                               input bit holdReq, input bit expectImmediate);
    int  latency;
    int  n;
    bit  timedOut;
    bit  completing;
    timedOut = (waits >= TO);
    latency  = timedOut ? 2 + TO : 3 + waits;
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    wdata_i = wdata;
    randomBus();
    #1;
    n = 0;
    while (!gnt_o && n < 20) begin
      nextCycle();
      randomBus();
      #1;
      n++;
    end
    checkOutput("gnt", 64'(gnt_o), 64'd1);
    if (expectImmediate) checkOutput("gnt_same_cycle_delay", 64'(n), 64'd0);
    if (!gnt_o) begin
      req_i = 1'b0;
      return;
    end
    for (int k = 1; k <= latency; k++) begin
      nextCycle();
      req_i = holdReq && (k < latency);
      randomCore();
      if (k < latency) begin
        checkOutput("psel", 64'(PSEL), 64'd1);
        checkOutput("penable", 64'(PENABLE), 64'(k >= 2));
        checkOutput("rvalid_early", 64'(rvalid_o), 64'd0);
        checkOutput("rdata_hold", rdata_o, expRdata);
        checkOutput("paddr", 64'(PADDR), 64'(addr));
        checkOutput("pwdata", PWDATA, wdata);
        checkOutput("pwrite", 64'(PWRITE), 64'(we));
        if (k >= 2) begin
          completing = (k - 2 == waits);
          PREADY  = completing;
          PSLVERR = completing ? slverr : 1'($urandom);
          PRDATA  = completing ? prdata : {$urandom, $urandom};
        end else begin
          randomBus();
        end
        if (holdReq) begin
          #1;
          checkOutput("gnt_busy", 64'(gnt_o), 64'd0);
        end
      end else begin
        expRdata = timedOut ? 64'd0 : (we ? 64'd0 : prdata);
        expErr   = timedOut ? 1'b1 : slverr;
        checkOutput("rsp_psel", 64'(PSEL), 64'd0);
        checkOutput("rsp_penable", 64'(PENABLE), 64'd0);
        checkOutput("rsp_rvalid", 64'(rvalid_o), 64'd1);
        checkOutput("rsp_rdata", rdata_o, expRdata);
        checkOutput("rsp_err", 64'(err_o), 64'(expErr));
        checkOutput("rsp_paddr_hold", 64'(PADDR), 64'(addr));
        randomBus();
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit prevB2b;
    bit b2bNext;
    HRESET = 1'b1;
    req_i  = 1'b1;
    randomCore();
    randomBus();
    nextCycle();
    nextCycle();
    checkOutput("reset_psel", 64'(PSEL), 64'd0);
    checkOutput("reset_penable", 64'(PENABLE), 64'd0);
    checkOutput("reset_rvalid", 64'(rvalid_o), 64'd0);
    checkOutput("reset_rdata", rdata_o, 64'd0);
    checkOutput("reset_err", 64'(err_o), 64'd0);
    checkOutput("reset_paddr", 64'(PADDR), 64'd0);
    checkOutput("reset_pwdata", PWDATA, 64'd0);
    checkOutput("reset_pwrite", 64'(PWRITE), 64'd0);
    #1;
    checkOutput("reset_gnt", 64'(gnt_o), 64'd0);
    HRESET = 1'b0;
    idleCycles(2);

    $display("[TB] directed: zero-wait write, wait-state read, slave error");
    applyStimulus(1'b1, 12'h008, 64'h1234, 0, 1'b0, 64'h0, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 12'h000, 64'h0, 3, 1'b0, 64'hDEAD_BEEF_0000_0042, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 12'hFF8, 64'h0, 0, 1'b1, 64'h55, 1'b0, 1'b0);
    idleCycles(1);

    $display("[TB] directed: timeout, immediate regrant, PREADY on last cycle");
    applyStimulus(1'b0, 12'h100, 64'h0, 10, 1'b0, 64'h77, 1'b0, 1'b0);
    applyStimulus(1'b0, 12'h108, 64'h0, TO - 1, 1'b0, 64'hCAFE, 1'b0, 1'b1);
    idleCycles(1);

    $display("[TB] directed: back-to-back writes");
    applyStimulus(1'b1, 12'h008, 64'h1, 0, 1'b0, 64'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 12'h010, 64'h2, 0, 1'b0, 64'h0, 1'b0, 1'b1);
    idleCycles(1);

    $display("[TB] randomized transfers");
    prevB2b = 1'b0;
    for (int t = 0; t < 40; t++) begin
      b2bNext = ($urandom_range(0, 2) == 0);
      applyStimulus(1'($urandom), AW'($urandom) & 12'hFF8, {$urandom, $urandom},
                    int'($urandom_range(0, 6)), 1'($urandom), {$urandom, $urandom},
                    b2bNext, prevB2b);
      if (!b2bNext) idleCycles(int'($urandom_range(1, 2)));
      prevB2b = b2bNext;
    end

    $display("[TB] directed: reset mid-ACCESS");
    applyStimulus(1'b0, 12'h018, 64'h0, 0, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    idleCycles(1);
    req_i   = 1'b1;
    we_i    = 1'b0;
    addr_i  = 12'h020;
    wdata_i = 64'hABCD;
    #1;
    checkOutput("rst_test_gnt", 64'(gnt_o), 64'd1);
    nextCycle();
    req_i = 1'b0;
    nextCycle();
    PREADY = 1'b0;
    nextCycle();
    PREADY = 1'b0;
    checkOutput("rst_test_in_access", 64'(PENABLE), 64'd1);
    HRESET = 1'b1;
    req_i  = 1'b1;
    #1;
    checkOutput("rst_test_gnt_in_reset", 64'(gnt_o), 64'd0);
    nextCycle();
    checkOutput("rst_mid_psel", 64'(PSEL), 64'd0);
    checkOutput("rst_mid_penable", 64'(PENABLE), 64'd0);
    checkOutput("rst_mid_rvalid", 64'(rvalid_o), 64'd0);
    checkOutput("rst_mid_rdata", rdata_o, 64'd0);
    checkOutput("rst_mid_err", 64'(err_o), 64'd0);
    checkOutput("rst_mid_paddr", 64'(PADDR), 64'd0);
    checkOutput("rst_mid_pwdata", PWDATA, 64'd0);
    expRdata = 64'd0;
    expErr   = 1'b0;
    HRESET = 1'b0;
    idleCycles(3);
    applyStimulus(1'b0, 12'h040, 64'h0, 1, 1'b0, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
    idleCycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
